// File: rtl/stream_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin stream arbiter.
package stream_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

    localparam int BEAT_TOTAL_W = 16;

endpackage

// File: rtl/stream_rr_arbiter_if.sv
// Requester-side and consumer-side stream signals of the arbiter.
interface stream_rr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          out_valid;
    logic [DATA_WIDTH-1:0]         out_data;
    logic                          out_ready;

    modport slave (
        input  req_valid, req_data, req_last, out_ready,
        output req_ready, out_valid, out_data
    );

    modport master (
        output req_valid, req_data, req_last, out_ready,
        input  req_ready, out_valid, out_data
    );
endinterface

// File: rtl/stream_rr_arbiter_rr_pick.sv
// Rotating priority encoder: first valid index after ptr, modulo NUM_REQ.
module rr_pick
    import stream_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    int unsigned cand;

    // Wrap by subtraction so non-power-of-two NUM_REQ works.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && valid[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin burst arbiter feeding a single ready/valid stream consumer.
module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    localparam int IDX_W     = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    stream_rr_arbiter_if.slave      bus,
    output logic                    grant_active,
    output logic [IDX_W-1:0]        grant_id,
    output logic [BEAT_TOTAL_W-1:0] beat_total
);

    arb_state_t              state;
    arb_state_t              state_nxt;
    logic [IDX_W-1:0]        grant_q;
    logic [IDX_W-1:0]        ptr_q;
    logic [IDX_W-1:0]        pick_idx;
    logic                    pick_found;
    logic [7:0]              beat_cnt;
    logic [BEAT_TOTAL_W-1:0] total_q;
    logic                    accept;
    logic                    burst_end;
    logic                    cur_valid;
    logic                    cur_last;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .valid (bus.req_valid),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign cur_valid = bus.req_valid[grant_q];
    assign cur_last  = bus.req_last[grant_q];

    // Outputs are forced low during reset, even before the FSM has been cleared.
    always_comb begin
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        bus.req_ready = '0;
        grant_active  = 1'b0;
        if (!rst && state == ARB_GRANT) begin
            grant_active           = 1'b1;
            bus.out_valid          = cur_valid;
            bus.out_data           = bus.req_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
            bus.req_ready[grant_q] = bus.out_ready;
        end
    end

    assign accept     = bus.out_valid & bus.out_ready;
    assign burst_end  = accept && (cur_last || ({1'b0, beat_cnt} + 9'd1 == 9'(MAX_BURST)));
    assign grant_id   = rst ? '0 : grant_q;
    assign beat_total = rst ? '0 : total_q;

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:  if (pick_found) state_nxt = ARB_GRANT;
            ARB_GRANT: if (burst_end)  state_nxt = ARB_IDLE;
            default:   state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q    <= IDX_W'(NUM_REQ - 1);
            grant_q  <= '0;
            beat_cnt <= '0;
            total_q  <= '0;
        end else begin
            if (state == ARB_IDLE && pick_found) begin
                grant_q  <= pick_idx;
                beat_cnt <= '0;
            end
            if (accept) begin
                beat_cnt <= beat_cnt + 8'd1;
                total_q  <= total_q + 16'd1;
            end
            if (burst_end) begin
                ptr_q <= grant_q;
            end
        end
    end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed self-checking bench for stream_rr_arbiter.
module tb_stream_rr_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stream_rr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus ();
    stream_rr_arbiter_if #(.NUM_REQ(3), .DATA_WIDTH(8)) bus_w ();

    logic        ga;
    logic [1:0]  gid;
    logic [15:0] tot;
    logic        ga_w;
    logic [1:0]  gid_w;
    logic [15:0] tot_w;

    int n_checks = 0;
    int n_fail   = 0;

    stream_rr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .grant_active (ga),
        .grant_id     (gid),
        .beat_total   (tot)
    );

    stream_rr_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8), .MAX_BURST(255)) dut_w (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus_w.slave),
        .grant_active (ga_w),
        .grant_id     (gid_w),
        .beat_total   (tot_w)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic clear_inputs();
        bus.req_valid   = '0;
        bus.req_data    = '0;
        bus.req_last    = '0;
        bus.out_ready   = 1'b1;
        bus_w.req_valid = '0;
        bus_w.req_data  = '0;
        bus_w.req_last  = '0;
        bus_w.out_ready = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        bus.req_valid = 4'b0001;
        bus.req_data  = 32'h0000_00EE;
        step();
        step();
        settle();
        n_checks++; if (ga !== 1'b0) begin n_fail++; $display("FAIL reset_grant_active: got %0d expected 0", ga); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0d expected 0", bus.out_valid); end
        n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready); end
        n_checks++; if (bus.out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h expected 00", bus.out_data); end
        n_checks++; if (tot !== 16'd0 || gid !== 2'd0) begin n_fail++; $display("FAIL reset_counters: got total=%0d id=%0d expected 0/0", tot, gid); end
        clear_inputs();
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        do_reset();
        bus.req_valid = 4'b0001;
        bus.req_data  = 32'h0000_00A1;
        settle();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_idle_valid: got %0d expected 0", bus.out_valid); end
        step();
        settle();
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA1) begin n_fail++; $display("FAIL single_beat1: got v=%0d d=%h expected 1/a1", bus.out_valid, bus.out_data); end
        n_checks++; if (bus.req_ready !== 4'b0001 || gid !== 2'd0) begin n_fail++; $display("FAIL single_ready: got %b id=%0d expected 0001/0", bus.req_ready, gid); end
        step();
        bus.req_data = 32'h0000_00A2;
        settle();
        n_checks++; if (bus.out_data !== 8'hA2 || tot !== 16'd1) begin n_fail++; $display("FAIL single_beat2: got d=%h total=%0d expected a2/1", bus.out_data, tot); end
        step();
        bus.req_data = 32'h0000_00A3;
        bus.req_last = 4'b0001;
        settle();
        n_checks++; if (bus.out_data !== 8'hA3 || bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_beat3: got d=%h rdy=%b expected a3/0001", bus.out_data, bus.req_ready); end
        step();
        bus.req_valid = '0;
        bus.req_last  = '0;
        settle();
        n_checks++; if (ga !== 1'b0 || tot !== 16'd3) begin n_fail++; $display("FAIL single_done: got ga=%0d total=%0d expected 0/3", ga, tot); end
        n_checks++; if (bus.out_data !== 8'h00) begin n_fail++; $display("FAIL single_idle_data: got %h expected 00", bus.out_data); end
        step();
    endtask

    task automatic test_round_robin();
        int exp_id;
        do_reset();
        bus.req_valid = 4'b1111;
        bus.req_last  = 4'b1111;
        bus.req_data  = 32'h2322_2120;
        for (int k = 0; k < 5; k++) begin
            exp_id = k % 4;
            settle();
            n_checks++; if (ga !== 1'b0) begin n_fail++; $display("FAIL rr_bubble_%0d: got ga=%0d expected 0", k, ga); end
            step();
            settle();
            n_checks++; if (ga !== 1'b1 || gid !== 2'(exp_id)) begin n_fail++; $display("FAIL rr_grant_%0d: got ga=%0d id=%0d expected 1/%0d", k, ga, gid, exp_id); end
            n_checks++; if (bus.out_data !== 8'(8'h20 + exp_id) || bus.req_ready !== 4'(1 << exp_id)) begin n_fail++; $display("FAIL rr_data_%0d: got d=%h rdy=%b expected %h/%b", k, bus.out_data, bus.req_ready, 8'(8'h20 + exp_id), 4'(1 << exp_id)); end
            step();
        end
        bus.req_valid = '0;
        bus.req_last  = '0;
        settle();
        n_checks++; if (tot !== 16'd5) begin n_fail++; $display("FAIL rr_total: got %0d expected 5", tot); end
        step();
    endtask

    task automatic test_max_burst();
        int beat;
        int grants;
        int run;
        logic prev;
        do_reset();
        beat = 0; grants = 0; run = 0; prev = 1'b0;
        bus.req_valid = 4'b0100;
        bus.req_data  = '0;
        for (int c = 0; c < 60 && beat < 10; c++) begin
            settle();
            if (ga && !prev) grants++;
            if (prev && !ga) begin
                n_checks++; if (run !== 4) begin n_fail++; $display("FAIL maxb_burst_len: got %0d expected 4", run); end
                run = 0;
            end
            if (bus.out_valid && bus.out_ready) begin
                n_checks++; if (bus.out_data !== 8'(beat) || gid !== 2'd2) begin n_fail++; $display("FAIL maxb_beat_%0d: got d=%h id=%0d expected %h/2", beat, bus.out_data, gid, 8'(beat)); end
                beat++;
                run++;
            end
            prev = ga;
            step();
            bus.req_data[2*8 +: 8] = 8'(beat);
            if (beat == 10) bus.req_valid = '0;
        end
        settle();
        n_checks++; if (beat !== 10) begin n_fail++; $display("FAIL maxb_timeout: got %0d beats expected 10", beat); end
        n_checks++; if (grants !== 3) begin n_fail++; $display("FAIL maxb_grants: got %0d expected 3", grants); end
        n_checks++; if (tot !== 16'd10) begin n_fail++; $display("FAIL maxb_total: got %0d expected 10", tot); end
        n_checks++; if (ga !== 1'b1 || bus.out_valid !== 1'b0 || gid !== 2'd2) begin n_fail++; $display("FAIL maxb_hold: got ga=%0d v=%0d id=%0d expected 1/0/2", ga, bus.out_valid, gid); end
    endtask

    task automatic test_backpressure();
        int beat;
        do_reset();
        beat = 0;
        bus.req_valid = 4'b0010;
        bus.req_data  = 32'h0000_4000;
        for (int c = 0; c < 30; c++) begin
            bus.out_ready = (c % 2 == 0);
            settle();
            if (ga) begin
                n_checks++; if (bus.req_ready !== (bus.out_ready ? 4'b0010 : 4'b0000)) begin n_fail++; $display("FAIL bp_ready_c%0d: got %b expected %b", c, bus.req_ready, bus.out_ready ? 4'b0010 : 4'b0000); end
                n_checks++; if (tot !== 16'(beat)) begin n_fail++; $display("FAIL bp_total_c%0d: got %0d expected %0d", c, tot, beat); end
            end
            if (bus.out_valid && bus.out_ready) begin
                n_checks++; if (bus.out_data !== 8'(8'h40 + beat)) begin n_fail++; $display("FAIL bp_data_%0d: got %h expected %h", beat, bus.out_data, 8'(8'h40 + beat)); end
                beat++;
            end
            step();
            if (beat == 4) begin
                bus.req_valid = '0;
                bus.req_last  = '0;
                break;
            end
            bus.req_data[1*8 +: 8] = 8'(8'h40 + beat);
            bus.req_last[1]        = (beat == 3);
        end
        bus.out_ready = 1'b1;
        settle();
        n_checks++; if (beat !== 4 || ga !== 1'b0 || tot !== 16'd4) begin n_fail++; $display("FAIL bp_done: got beats=%0d ga=%0d total=%0d expected 4/0/4", beat, ga, tot); end
        step();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        bus.req_valid = 4'b1000;
        bus.req_data  = 32'h3000_0000;
        settle();
        step();
        settle();
        n_checks++; if (gid !== 2'd3 || bus.out_data !== 8'h30) begin n_fail++; $display("FAIL rstmid_beat1: got id=%0d d=%h expected 3/30", gid, bus.out_data); end
        step();
        bus.req_data = 32'h3100_0000;
        rst = 1'b1;
        settle();
        n_checks++; if (bus.out_valid !== 1'b0 || bus.req_ready !== 4'b0000 || tot !== 16'd0) begin n_fail++; $display("FAIL rstmid_gated: got v=%0d rdy=%b total=%0d expected 0/0000/0", bus.out_valid, bus.req_ready, tot); end
        step();
        settle();
        n_checks++; if (ga !== 1'b0 || tot !== 16'd0 || gid !== 2'd0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_cleared: got ga=%0d total=%0d id=%0d v=%0d expected 0/0/0/0", ga, tot, gid, bus.out_valid); end
        step();
        rst = 1'b0;
        bus.req_valid = 4'b1001;
        bus.req_last  = 4'b1001;
        bus.req_data  = 32'h3300_0050;
        settle();
        n_checks++; if (ga !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: got ga=%0d expected 0", ga); end
        step();
        settle();
        n_checks++; if (gid !== 2'd0 || bus.req_ready !== 4'b0001 || bus.out_data !== 8'h50) begin n_fail++; $display("FAIL rstmid_req0_wins: got id=%0d rdy=%b d=%h expected 0/0001/50", gid, bus.req_ready, bus.out_data); end
        step();
        clear_inputs();
        step();
    endtask

    task automatic test_wrap();
        int count;
        count = 0;
        do_reset();
        bus_w.req_valid = 3'b001;
        bus_w.req_data  = 24'h00_005A;
        for (int c = 0; c < 70000; c++) begin
            settle();
            if (count == 65535 && c % 256 == 0) begin
                n_checks++; if (tot_w !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_ffff: got %h expected ffff", tot_w); end
            end
            if (count == 65536) begin
                n_checks++; if (tot_w !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero: got %h expected 0000", tot_w); end
            end
            if (bus_w.out_valid && bus_w.out_ready) count++;
            step();
            if (count == 65537) break;
        end
        bus_w.req_valid = '0;
        settle();
        n_checks++; if (count !== 65537) begin n_fail++; $display("FAIL wrap_timeout: got %0d beats expected 65537", count); end
        n_checks++; if (tot_w !== 16'd1) begin n_fail++; $display("FAIL wrap_total: got %0d expected 1", tot_w); end
        n_checks++; if (gid_w !== 2'd0 || ga_w !== 1'b1) begin n_fail++; $display("FAIL wrap_grant: got id=%0d ga=%0d expected 0/1", gid_w, ga_w); end
        step();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_max_burst();
        test_backpressure();
        test_reset_mid_burst();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
